// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB
// over a single req/ready memory port. Illegal or misaligned operations halt until reset.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);
    localparam int         AW      = (NREGS == 16) ? 4 : 5;
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23;
    localparam logic [6:0] OP_IMM = 7'h13, OP_REG   = 7'h33;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        mem_req_q, mem_we_q, retire_q, halted_q;
    logic [31:0] rf_q [NREGS];

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_d, op_b, alu_out, alu_d, br_next, pc_plus4, wb_data, wb_pc;
    logic        legal_d, use_rd, use_rs1, use_rs2, illegal_d, br_taken, rf_we;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign f3       = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign f7       = ir_q[31:25];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        legal_d = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm_d   = {{20{ir_q[31]}}, ir_q[31:20]};
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                legal_d = 1'b1;
                use_rd  = 1'b1;
                imm_d   = {ir_q[31:12], 12'b0};
            end
            OP_JAL: begin
                legal_d = 1'b1;
                use_rd  = 1'b1;
                imm_d   = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            end
            OP_JALR: begin
                legal_d = (f3 == 3'b000);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_BR: begin
                legal_d = (f3[2:1] != 2'b01);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_d   = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            end
            OP_LD: begin
                legal_d = (f3 == 3'b010);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_ST: begin
                legal_d = (f3 == 3'b010);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_d   = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
            end
            OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                if (f3 == 3'b001)      legal_d = (f7 == 7'h00);
                else if (f3 == 3'b101) legal_d = (f7 == 7'h00) || (f7 == 7'h20);
                else                   legal_d = 1'b1;
            end
            OP_REG: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                legal_d = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
            end
            default: legal_d = 1'b0;
        endcase
        // RV32E: a reference to x16..x31 in any used field is illegal
        illegal_d = !legal_d
                  || (use_rd  && {1'b0, rd}  >= NREGS_L)
                  || (use_rs1 && {1'b0, rs1} >= NREGS_L)
                  || (use_rs2 && {1'b0, rs2} >= NREGS_L);
    end

    always_comb begin
        op_b = (opcode == OP_REG) ? b_q : imm_q;
        case (f3)
            3'b000:  alu_out = (opcode == OP_REG && f7[5]) ? a_q - op_b : a_q + op_b;
            3'b001:  alu_out = a_q << op_b[4:0];
            3'b010:  alu_out = {31'b0, $signed(a_q) < $signed(op_b)};
            3'b011:  alu_out = {31'b0, a_q < op_b};
            3'b100:  alu_out = a_q ^ op_b;
            3'b101:  alu_out = ir_q[30] ? 32'($signed(a_q) >>> op_b[4:0]) : a_q >> op_b[4:0];
            3'b110:  alu_out = a_q | op_b;
            default: alu_out = a_q & op_b;
        endcase
        case (f3)
            3'b000:  br_taken = (a_q == b_q);
            3'b001:  br_taken = (a_q != b_q);
            3'b100:  br_taken = ($signed(a_q) <  $signed(b_q));
            3'b101:  br_taken = ($signed(a_q) >= $signed(b_q));
            3'b110:  br_taken = (a_q <  b_q);
            3'b111:  br_taken = (a_q >= b_q);
            default: br_taken = 1'b0;
        endcase
        br_next = br_taken ? pc_q + imm_q : pc_plus4;
        case (opcode)
            OP_LUI:          alu_d = imm_q;
            OP_AUIPC, OP_JAL: alu_d = pc_q + imm_q;
            OP_JALR:         alu_d = (a_q + imm_q) & ~32'd1;
            OP_LD, OP_ST:    alu_d = a_q + imm_q;
            default:         alu_d = alu_out;
        endcase
        // For jumps alu_q carries the target, so the link value comes from pc+4
        if (opcode == OP_JAL || opcode == OP_JALR) begin
            wb_data = pc_plus4;
            wb_pc   = alu_q;
        end else begin
            wb_data = (opcode == OP_LD) ? mdr_q : alu_q;
            wb_pc   = pc_plus4;
        end
    end

    assign rf_we = !reset && (state_q == S_WB) && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rd[AW-1:0]] <= wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (mem_req_q && mem_ready) begin
                        ir_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end else begin
                        // Only needed on the first fetch after reset; later fetches are pre-issued
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end
                end
                S_DECODE: begin
                    a_q   <= (rs1 == 5'd0) ? 32'd0 : rf_q[rs1[AW-1:0]];
                    b_q   <= (rs2 == 5'd0) ? 32'd0 : rf_q[rs2[AW-1:0]];
                    imm_q <= imm_d;
                    if (illegal_d) begin
                        state_q  <= S_TRAP;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (opcode == OP_BR) begin
                        if (br_next[1:0] != 2'b00) begin
                            state_q  <= S_TRAP;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q       <= br_next;
                            retire_q   <= 1'b1;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= br_next;
                            state_q    <= S_FETCH;
                        end
                    end else if (opcode inside {OP_JAL, OP_JALR, OP_LD, OP_ST} && alu_d[1:0] != 2'b00) begin
                        state_q  <= S_TRAP;
                        halted_q <= 1'b1;
                    end else if (opcode == OP_LD || opcode == OP_ST) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (opcode == OP_ST);
                        mem_addr_q  <= alu_d;
                        mem_wdata_q <= b_q;
                        state_q     <= S_MEM;
                    end else begin
                        alu_q   <= alu_d;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_req_q && mem_ready) begin
                        if (mem_we_q) begin
                            pc_q       <= pc_plus4;
                            retire_q   <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_plus4;
                            state_q    <= S_FETCH;
                        end else begin
                            mdr_q     <= mem_rdata;
                            mem_req_q <= 1'b0;
                            state_q   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc_q       <= wb_pc;
                    retire_q   <= 1'b1;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= wb_pc;
                    state_q    <= S_FETCH;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    halted_q  <= 1'b1;
                    state_q   <= S_TRAP;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
endmodule
